// File: rtl/mips_mult_seq_pkg.sv
// Shared constants and types for the sequential MIPS32 MULT/MULTU back end.

package mips_mult_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mips_mult_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.

interface mips_mult_seq_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, a_i, b_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i,
    output busy_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/mips_mult_seq_partial_product_gen.sv
// Partial product for one shift-add step: multiplicand gated by the current multiplier bit.

module partial_product_gen #(
  parameter int WIDTH = mips_mult_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] mcand_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] pp_o
);

  assign pp_o = mcand_i & {WIDTH{bit_i}};

endmodule

// File: rtl/mips_mult_seq.sv
// Sequential 32x32->64 shift-add multiplier writing HI/LO for MULT/MULTU.
// Signed MULT support is compiled in only when MULT_SIGNED_EN is defined.

module mips_mult_seq
  import mips_mult_pkg::*;
#(
  parameter int WIDTH = mips_mult_pkg::WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mips_mult_seq_if.slave bus
);

  localparam int PW = 2 * WIDTH + 1;

  state_e             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] result;
  logic               start_acc;
  logic               last_run;

  assign start_acc = (state_q == IDLE) && bus.start_i;
  assign last_run  = (cnt_q == CNT_W'(ITER));

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  always_comb begin
    mag_a  = magnitude(bus.a_i, bus.signed_i);
    mag_b  = magnitude(bus.b_i, bus.signed_i);
    result = apply_sign(p_q[2*WIDTH-1:0], neg_q);
    neg_d  = neg_q;
    if (start_acc) neg_d = bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`else
  logic unused_signed;

  assign unused_signed = bus.signed_i;
  assign mag_a         = bus.a_i;
  assign mag_b         = bus.b_i;
  assign result        = p_q[2*WIDTH-1:0];
`endif

  partial_product_gen #(
    .WIDTH (WIDTH)
  ) u_ppg (
    .mcand_i (mcand_q),
    .bit_i   (p_q[0]),
    .pp_o    (pp)
  );

  // P[64] is always zero entering a step, so this is the 33-bit add of P[63:32].
  assign sum = p_q[PW-1:WIDTH] + {1'b0, pp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = RUN;
      RUN:     if (last_run)    state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // The RUN cycle after the 32nd step publishes the settled product into HI/LO.
  always_comb begin
    p_d     = p_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mcand_d = mag_a;
          p_d     = {1'b0, {WIDTH{1'b0}}, mag_b};
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!last_run) begin
          p_d   = {1'b0, sum, p_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end else begin
          hi_d = result[2*WIDTH-1:WIDTH];
          lo_d = result[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy_o = (state_q != IDLE);
    bus.done_o = (state_q == DONE);
    bus.hi_o   = hi_q;
    bus.lo_o   = lo_q;
  end

endmodule

// File: tb/tb_mips_mult_seq.sv
// Randomised self-checking bench for mips_mult_seq against an arithmetic product model.

module tb_mips_mult_seq;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips_mult_seq_if #(.WIDTH(32)) bus ();

  mips_mult_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Launch one op at the next edge (edge 0); optionally pulse an intruding start before edge intr.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int intr);
    logic [63:0] exp;
    int done_cnt, done_at, busy_cnt;
    exp = model(a, b, s);
    bus.a_i = a; bus.b_i = b; bus.signed_i = s; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    done_cnt = 0; done_at = -1; busy_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == intr) begin
        bus.start_i = 1'b1; bus.a_i = 32'd9; bus.b_i = 32'd9; bus.signed_i = ~s;
      end
      @(posedge clk); #1;
      if (c == intr) bus.start_i = 1'b0;
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin done_cnt++; done_at = c; end
    end
    chk("hi", 64'(bus.hi_o), 64'(exp[63:32]));
    chk("lo", 64'(bus.lo_o), 64'(exp[31:0]));
    chk("done_edge", 64'(done_at), 64'd33);
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    @(posedge clk); #1;
    if (bus.done_o) done_cnt++;
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after", 64'(bus.busy_o), 64'd0);
    chk("hold", {bus.hi_o, bus.lo_o}, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          seen_done;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.a_i = '0; bus.b_i = '0;

    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_lo", 64'(bus.lo_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0);
    run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_op(32'd5, 32'd6, 1'b0, 10);
    run_op(32'd0, 32'h1234_5678, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);

    bus.a_i = 32'd3; bus.b_i = 32'd4; bus.signed_i = 1'b0; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    seen_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.done_o) seen_done++;
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_done", 64'(bus.done_o), 64'd0);
    chk("abort_out", {bus.hi_o, bus.lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) seen_done++;
    end
    chk("abort_quiet", 64'(seen_done), 64'd0);
    run_op(32'd3, 32'd4, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (n % 6 == 1) ra = 32'h8000_0000;
      if (n % 6 == 3) rb = 32'hFFFF_FFFF;
      run_op(ra, rb, rs, (n % 4 == 0) ? int'($urandom_range(1, 33)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
